// File: rtl/reg_dump_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_dump_sequencer_if
//  Description : Bundles the dump sequencer's command, register-file debug
//                port and UART TX handshake signals. Signal prefixes are
//                named from the sequencer's point of view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface reg_dump_sequencer_if #(
    parameter int NB      = 32,
    parameter int REGS    = 5,
    parameter int BYTE_NB = 8
);
    logic                i_start;
    logic [NB-1:0]       i_reg_data;
    logic                i_tx_done;
    logic [REGS-1:0]     o_select_reg_dir;
    logic [BYTE_NB-1:0]  o_tx_data;
    logic                o_tx_start;
    logic                o_busy;
    logic                o_done;

    // Sequencer side.
    modport slave (
        input  i_start, i_reg_data, i_tx_done,
        output o_select_reg_dir, o_tx_data, o_tx_start, o_busy, o_done
    );

    // Command decoder / register file / UART side.
    modport master (
        output i_start, i_reg_data, i_tx_done,
        input  o_select_reg_dir, o_tx_data, o_tx_start, o_busy, o_done
    );
endinterface
`default_nettype wire

// File: rtl/reg_dump_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : reg_dump_sequencer
//  Description : Walks the register file through its debug read port and
//                streams every register to the UART TX, MSB byte first,
//                using a start/done handshake per byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_dump_sequencer #(
    parameter int NB      = 32,
    parameter int REGS    = 5,
    parameter int TAM_REG = 32,
    parameter int BYTE_NB = 8
) (
    input  wire logic           i_clk,
    input  wire logic           i_reset,
    reg_dump_sequencer_if.slave bus
);

    localparam int BYTES_PER_REG = NB / BYTE_NB;
    // Keep the byte counter at least one bit wide when a register is one byte.
    localparam int BC_W = (BYTES_PER_REG > 1) ? $clog2(BYTES_PER_REG) : 1;

    localparam logic [BC_W-1:0] c_LAST_BYTE = BC_W'(BYTES_PER_REG - 1);
    localparam logic [REGS-1:0] c_LAST_IDX  = REGS'(TAM_REG - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LATCH = 3'd1,
        S_SEND  = 3'd2,
        S_WAIT  = 3'd3,
        S_NEXT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [REGS-1:0]   r_idx;
    logic [REGS-1:0]   w_idx_nxt;
    logic [BC_W-1:0]   r_bcnt;
    logic [BC_W-1:0]   w_bcnt_nxt;
    logic [NB-1:0]     r_shift;
    logic [NB-1:0]     w_shift_nxt;

    // State and datapath registers; reset wins over every other input.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_bcnt  <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // Next-state and datapath update for the dump walk.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_bcnt_nxt  = r_bcnt;
        w_shift_nxt = r_shift;
        case (r_state)
            S_IDLE: begin
                if (bus.i_start) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = S_LATCH;
                end
            end
            S_LATCH: begin
                // Select has been stable since the previous edge, so the
                // combinational read data is valid here.
                w_shift_nxt = bus.i_reg_data;
                w_bcnt_nxt  = '0;
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (bus.i_tx_done) begin
                    if (r_bcnt == c_LAST_BYTE) begin
                        w_state_nxt = S_NEXT;
                    end else begin
                        w_shift_nxt = r_shift << BYTE_NB;
                        w_bcnt_nxt  = r_bcnt + BC_W'(1);
                        w_state_nxt = S_SEND;
                    end
                end
            end
            S_NEXT: begin
                if (r_idx == c_LAST_IDX) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_idx_nxt   = r_idx + REGS'(1);
                    w_state_nxt = S_LATCH;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the registered state and datapath.
    assign bus.o_select_reg_dir = r_idx;
    assign bus.o_tx_data        = r_shift[NB-1 -: BYTE_NB];
    assign bus.o_tx_start       = (r_state == S_SEND);
    assign bus.o_busy           = (r_state != S_IDLE);
    assign bus.o_done           = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_reg_dump_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_dump_sequencer
//  Description : Scoreboard bench for reg_dump_sequencer with a register-file
//                model and a UART TX model of configurable latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_dump_sequencer;

    localparam int NB      = 32;
    localparam int REGS    = 5;
    localparam int TAM_REG = 32;
    localparam int BYTE_NB = 8;
    localparam int BPR     = NB / BYTE_NB;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic spur;
    logic model_done;
    int   tx_delay;
    int   tx_cnt;
    logic [7:0] tx_held;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] sb[$];
    logic [7:0] log_q[$];
    int   done_cnt        = 0;
    int   last_done_cyc   = 0;
    int   first_start_cyc = -1;
    bit   want_first      = 1'b0;
    int   c0;

    reg_dump_sequencer_if #(.NB(NB), .REGS(REGS), .BYTE_NB(BYTE_NB)) bus ();

    reg_dump_sequencer #(
        .NB(NB), .REGS(REGS), .TAM_REG(TAM_REG), .BYTE_NB(BYTE_NB)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    function automatic logic [31:0] reg_model(input logic [4:0] idx);
        if (idx == 5'd1)  return 32'h11223344;
        if (idx == 5'd31) return 32'hDEADBEEF;
        return {4{3'b000, idx}};
    endfunction

    assign bus.i_start    = start;
    assign bus.i_tx_done  = model_done | spur;
    assign bus.i_reg_data = reg_model(bus.o_select_reg_dir);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every byte request.
    always @(negedge clk) begin
        logic [7:0] exp_b;
        if (bus.o_tx_start === 1'b1) begin
            if (want_first) begin
                first_start_cyc = cyc;
                want_first      = 1'b0;
            end
            log_q.push_back(bus.o_tx_data);
            check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                exp_b = sb.pop_front();
                check("tx_byte", 64'(bus.o_tx_data), 64'(exp_b));
            end
        end
        if (bus.o_done === 1'b1) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
    end

    // UART TX model: acknowledges each byte tx_delay cycles after its start
    // and checks the byte stays put while waiting.
    initial begin
        tx_cnt     = 0;
        tx_held    = 8'h00;
        model_done = 1'b0;
        forever begin
            @(negedge clk);
            model_done = 1'b0;
            if (rst) begin
                tx_cnt = 0;
            end else if (tx_cnt != 0) begin
                check("wait_data_stable", 64'(bus.o_tx_data), 64'(tx_held));
                check("wait_no_start", 64'(bus.o_tx_start), 64'd0);
                tx_cnt--;
                if (tx_cnt == 0) model_done = 1'b1;
            end
            if (!rst && bus.o_tx_start === 1'b1) begin
                tx_cnt  = tx_delay;
                tx_held = bus.o_tx_data;
            end
        end
    end

    task automatic push_dump();
        logic [31:0] w;
        for (int r = 0; r < TAM_REG; r++) begin
            w = reg_model(5'(r));
            for (int b = 0; b < BPR; b++) sb.push_back(w[31-8*b -: 8]);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        c0    = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int limit);
        for (int k = 0; k < limit; k++) begin
            if (done_cnt >= target) break;
            @(posedge clk);
        end
        check("done_reached", 64'(done_cnt), 64'(target));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_sel"},   64'(bus.o_select_reg_dir), 64'd0);
        check({tag, "_data"},  64'(bus.o_tx_data),        64'd0);
        check({tag, "_start"}, 64'(bus.o_tx_start),       64'd0);
        check({tag, "_busy"},  64'(bus.o_busy),           64'd0);
        check({tag, "_done"},  64'(bus.o_done),           64'd0);
    endtask

    task automatic check_dump_bytes(input string tag);
        logic [7:0] exp_head[8];
        logic [7:0] exp_tail[4];
        exp_head = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        exp_tail = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        check({tag, "_byte_count"}, 64'(log_q.size()), 64'd128);
        check({tag, "_sb_empty"},   64'(sb.size()),    64'd0);
        if (log_q.size() == 128) begin
            for (int i = 0; i < 8; i++) check({tag, "_head"}, 64'(log_q[i]), 64'(exp_head[i]));
            for (int i = 0; i < 4; i++) check({tag, "_tail"}, 64'(log_q[124+i]), 64'(exp_tail[i]));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_seen;
        int base;
        rst = 1'b1; start = 1'b0; spur = 1'b0; tx_delay = 1;

        // 1: reset with random activity on the inputs.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            start = 1'($urandom);
            spur  = 1'($urandom);
            @(negedge clk);
            check_idle_outputs("reset");
        end
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; spur = 1'b0;
        repeat (2) @(posedge clk);

        // 2: full dump with zero-wait TX and latency checks.
        tx_delay = 1;
        log_q.delete();
        push_dump();
        want_first = 1'b1;
        pulse_start();
        wait_done(1, 1000);
        check("first_start_latency", 64'(first_start_cyc), 64'(c0 + 2));
        check("done_latency",        64'(last_done_cyc),   64'(c0 + 321));
        check_dump_bytes("fast");
        @(negedge clk);
        check("idle_after_done", 64'(bus.o_busy), 64'd0);
        check("sel_holds_last", 64'(bus.o_select_reg_dir), 64'd31);

        // 3: slow TX.
        tx_delay = 20;
        log_q.delete();
        push_dump();
        pulse_start();
        wait_done(2, 5000);
        check_dump_bytes("slow");

        // 4: start while busy and spurious done in IDLE.
        tx_delay = 1;
        log_q.delete();
        push_dump();
        pulse_start();
        for (int k = 0; k < 200 && bus.o_select_reg_dir != 5'd7; k++) @(posedge clk);
        check("reached_reg7", 64'(bus.o_select_reg_dir), 64'd7);
        pulse_start();
        wait_done(3, 1000);
        repeat (20) @(posedge clk);
        check("no_restart_done_cnt", 64'(done_cnt), 64'd3);
        check_dump_bytes("busy_start");
        @(posedge clk); #1; spur = 1'b1;
        @(posedge clk); #1; spur = 1'b0;
        busy_seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.o_busy !== 1'b0) busy_seen++;
        end
        check("spurious_done_idle", 64'(busy_seen), 64'd0);
        check("spurious_no_bytes", 64'(log_q.size()), 64'd128);

        // 5: reset in WAIT of register 5 byte 2, then a clean dump.
        tx_delay = 20;
        log_q.delete();
        push_dump();
        pulse_start();
        for (int k = 0; k < 2000 && log_q.size() < 23; k++) @(posedge clk);
        check("reached_r5_b2", 64'(log_q.size()), 64'd23);
        check("r5_b2_sel", 64'(bus.o_select_reg_dir), 64'd5);
        repeat (3) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check_idle_outputs("midreset");
        tx_delay = 1;
        log_q.delete();
        push_dump();
        pulse_start();
        wait_done(4, 1000);
        check_dump_bytes("after_reset");

        // 6: start held high for back-to-back dumps.
        log_q.delete();
        push_dump();
        push_dump();
        base = done_cnt;
        @(posedge clk); #1; start = 1'b1;
        wait_done(base + 1, 1000);
        @(negedge clk);
        check("b2b_idle_gap", 64'(bus.o_busy), 64'd0);
        @(negedge clk);
        check("b2b_restart", 64'(bus.o_busy), 64'd1);
        @(posedge clk); #1; start = 1'b0;
        wait_done(base + 2, 1000);
        check("b2b_byte_count", 64'(log_q.size()), 64'd256);
        check("b2b_sb_empty",   64'(sb.size()),    64'd0);
        repeat (20) @(posedge clk);
        check("b2b_done_pulses", 64'(done_cnt - base), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_dump_sequencer.md
Name: reg_dump_sequencer

Overview:
Debug-side controller that walks the decode-stage register file through its debug read port and streams every register out to the UART transmitter, one byte at a time. It drives the register-select address and captures the combinational debug read data. It then serialises each word MSB-byte first using a start/done handshake with the TX unit. It sits between the debug unit's command decoder and the register file / UART TX, and replaces ad-hoc host-driven register polling.

Parameters:
NB, 32, register data width; must be a multiple of 8.
REGS, 5, register address width.
TAM_REG, 32, number of registers dumped, indices 0..TAM_REG-1; TAM_REG <= 2**REGS.
BYTE_NB, 8, UART byte width.

Ports:
i_clk  input  1  system clock, rising edge.
i_reset  input  1  synchronous, active-high reset.
i_start  input  1  dump request, sampled only in IDLE.
i_reg_data  input  NB  register-file debug read data; combinational function of o_select_reg_dir.
i_tx_done  input  1  one-cycle pulse from UART TX when the current byte has finished.
o_select_reg_dir  output  REGS  register index presented to the register-file debug port.
o_tx_data  output  BYTE_NB  byte to transmit.
o_tx_start  output  1  one-cycle request to UART TX.
o_busy  output  1  high whenever state != IDLE.
o_done  output  1  one-cycle pulse after the last byte of the last register.

Behaviour:
- One clock; reset is synchronous and active-high. All state is updated on the i_clk rising edge.
- Reset (any state, including mid-dump): state=IDLE, reg index=0, byte count=0, shift register=0. Outputs next cycle: o_select_reg_dir=0, o_tx_data=0, o_tx_start=0, o_busy=0, o_done=0. Reset has priority over all other inputs.
- Internal registers:
  - reg index, REGS bits; drives o_select_reg_dir directly.
  - byte count, clog2(NB/BYTE_NB) bits.
  - NB-bit shift register; o_tx_data = its top BYTE_NB bits.
- FSM states, all outputs Moore-decoded from state/registers:
  - IDLE: if i_start then index<=0 and go to LATCH; else stay.
  - LATCH: shift register<=i_reg_data (select has been stable since the previous edge); byte count<=0; go to SEND.
  - SEND: o_tx_start=1 for exactly this cycle; go to WAIT.
  - WAIT: hold o_tx_data stable.
    - On i_tx_done, if byte count==NB/BYTE_NB-1, go to NEXT.
    - On i_tx_done otherwise, shift register left by BYTE_NB, increment byte count, go to SEND.
    - No i_tx_done: stay; there is no timeout.
  - NEXT: if index==TAM_REG-1, go to DONE; else increment index and go to LATCH.
  - DONE: o_done=1 for this cycle; go to IDLE.
- Byte order: per register, MSB byte first (bits NB-1..NB-8 first). Registers are sent in ascending index order.
- Latency: with i_start high in cycle c, o_busy rises in c+1 (LATCH) and the first o_tx_start occurs in c+2.
- Per register: 2 + 2*(NB/BYTE_NB) cycles minimum (10 at defaults). With a zero-wait TX, o_done is at c+1+10*TAM_REG (c+321 at defaults).
- i_start while busy: ignored, with no queuing.
- i_tx_done outside WAIT: ignored.
- i_tx_done in the same cycle as SEND: ignored, because only WAIT samples it.
- No wrap-around: index never exceeds TAM_REG-1, and a completed dump always returns to IDLE.
- o_select_reg_dir holds its last value after DONE until the next start or reset.

Test Plan:
1. Reset: assert i_reset for 2 cycles mid-random inputs -> all outputs 0 and o_busy=0 in the cycle after the first reset edge.
2. Full dump, zero-wait TX model (i_tx_done one cycle after o_tx_start). Register model returns 0x11223344 for r1, 0xDEADBEEF for r31, index*0x01010101 elsewhere.
   - Required: 128 bytes, first four 00 00 00 00, r1 bytes 11 22 33 44, last four DE AD BE EF.
   - Required: first o_tx_start at c+2, o_done exactly at c+321.
3. Slow TX: i_tx_done 20 cycles after each o_tx_start -> o_tx_data stable throughout every WAIT, exactly one o_tx_start per byte, same 128-byte sequence.
4. i_start pulsed during register 7 of an active dump, and a spurious i_tx_done pulsed in IDLE -> no restart, no extra bytes, no state change in IDLE.
5. Reset asserted while in WAIT for register 5, byte 2 -> next cycle IDLE with all outputs 0. A new i_start then dumps from r0, byte 00.
6. Back-to-back: i_start held high continuously -> after o_done, IDLE for one cycle, then a second full dump starts, giving 256 bytes and two o_done pulses.
